// File: rtl/chaos_sample_uart_framer_if.sv
// Sample handshake between a chaotic-map core (master) and the UART framer (slave).
interface chaos_sample_uart_framer_if;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/chaos_sample_uart_framer.sv
// Buffers 64-bit samples in a small FIFO and sends each as a 10-byte 8N1 frame:
// sync byte, 8 sample bytes LSB first, XOR checksum of the sample bytes.
module chaos_sample_uart_framer #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    chaos_sample_uart_framer_if.slave s_if,
    output logic                      tx,
    output logic                      busy,
    output logic [15:0]               frames_sent
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       STOP_IDX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SYNC,
        ST_DATA,
        ST_CSUM
    } state_e;

    // FIFO storage and pointers
    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [63:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             s_ready_q, s_ready_d;

    // Frame engine
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [2:0]       byte_k_q, byte_k_d;
    logic [7:0]       cur_byte_q, cur_byte_d;
    logic [63:0]      sr_q, sr_d;
    logic [7:0]       csum_q, csum_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic [15:0]      frames_q, frames_d;

    logic push_c;
    logic pop_c;
    logic fifo_avail_c;

    assign push_c       = s_if.s_valid && s_ready_q;
    assign pop_c        = (state_q == ST_LOAD);
    // A push this cycle is already visible to LOAD on the next one.
    assign fifo_avail_c = (count_q != '0) || push_c;

    assign s_if.s_ready = s_ready_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign frames_sent  = frames_q;

    // FIFO next-state: write at tail, pop at head when the FSM loads a frame
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = s_if.s_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Ready looks only at occupancy, so a pop never opens a slot in the same cycle.
        s_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    // Frame FSM next-state, bit timing and registered tx/busy
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        byte_k_d   = byte_k_q;
        cur_byte_d = cur_byte_q;
        sr_d       = sr_q;
        csum_d     = csum_q;
        frames_d   = frames_q;
        tx_d       = 1'b1;
        busy_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fifo_avail_c) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sr_d       = mem_q[rd_ptr_q];
                csum_d     = 8'h00;
                cur_byte_d = SYNC_BYTE;
                bit_d      = 4'd0;
                div_d      = '0;
                state_d    = ST_SYNC;
            end
            ST_SYNC, ST_DATA, ST_CSUM: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (bit_q != STOP_IDX) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        bit_d = 4'd0;
                        if (state_q == ST_SYNC || (state_q == ST_DATA && byte_k_q != 3'd7)) begin
                            state_d    = ST_DATA;
                            byte_k_d   = (state_q == ST_SYNC) ? 3'd0 : byte_k_q + 3'd1;
                            cur_byte_d = sr_q[7:0];
                            csum_d     = csum_q ^ sr_q[7:0];
                            sr_d       = {8'h00, sr_q[63:8]};
                        end else if (state_q == ST_DATA) begin
                            state_d    = ST_CSUM;
                            cur_byte_d = csum_q;
                        end else begin
                            frames_d = frames_q + 16'd1;
                            state_d  = fifo_avail_c ? ST_LOAD : ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the bit the engine will be in next cycle.
        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_SYNC || state_d == ST_DATA || state_d == ST_CSUM) begin
            if (bit_d == 4'd0) begin
                tx_d = 1'b0;
            end else if (bit_d == STOP_IDX) begin
                tx_d = 1'b1;
            end else begin
                tx_d = cur_byte_d[3'(bit_d - 4'd1)];
            end
        end
    end

    // State registers; reset flushes the FIFO and abandons any frame
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s_ready_q  <= 1'b1;
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= 4'd0;
            byte_k_q   <= 3'd0;
            cur_byte_q <= 8'h00;
            sr_q       <= 64'h0;
            csum_q     <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            frames_q   <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s_ready_q  <= s_ready_d;
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            byte_k_q   <= byte_k_d;
            cur_byte_q <= cur_byte_d;
            sr_q       <= sr_d;
            csum_q     <= csum_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            frames_q   <= frames_d;
        end
    end

endmodule

// File: tb/tb_chaos_sample_uart_framer.sv
// Bench for chaos_sample_uart_framer: two instances (CLK_DIV 4 and 7), frame
// monitors decoding tx, and a byte scoreboard filled as samples are pushed.
module tb_chaos_sample_uart_framer;

    logic        clk;
    logic        reset;
    logic        tx4, busy4, tx7, busy7;
    logic [15:0] fs4, fs7;

    chaos_sample_uart_framer_if if4 ();
    chaos_sample_uart_framer_if if7 ();

    chaos_sample_uart_framer #(.CLK_DIV(4), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut4 (
        .clk(clk), .reset(reset), .s_if(if4), .tx(tx4), .busy(busy4), .frames_sent(fs4)
    );

    chaos_sample_uart_framer #(.CLK_DIV(7), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut7 (
        .clk(clk), .reset(reset), .s_if(if7), .tx(tx7), .busy(busy7), .frames_sent(fs7)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp4_q[$];
    logic [7:0]  exp7_q[$];
    int          gap4_q[$];
    int          blow4_q[$];
    int          fs4_q[$];
    int          frames_seen4 = 0;
    int          frames_seen7 = 0;
    logic [7:0]  last_csum4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected frame for one sample: sync, bytes LSB first, XOR of the data bytes.
    function automatic void sb_push(input bit use7, input logic [63:0] s);
        logic [7:0] fr [10];
        logic [7:0] c;
        c     = 8'h00;
        fr[0] = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            fr[k+1] = s[8*k +: 8];
            c       = c ^ s[8*k +: 8];
        end
        fr[9] = c;
        for (int k = 0; k < 10; k++) begin
            if (use7) exp7_q.push_back(fr[k]);
            else      exp4_q.push_back(fr[k]);
        end
    endfunction

    // Decodes frames on one tx line, checking every cycle of every bit.
    task automatic mon(input bit use7);
        int         div, idle, blow, bad, bsy, bit_i;
        bit         aborted;
        logic       t, b, first;
        logic [7:0] by [10];
        logic [7:0] e;
        div  = use7 ? 7 : 4;
        idle = 0;
        blow = 0;
        forever begin
            @(negedge clk);
            t = use7 ? tx7 : tx4;
            b = use7 ? busy7 : busy4;
            if (reset !== 1'b0) begin
                idle = 0;
                blow = 0;
            end else if (t === 1'b1) begin
                idle++;
                if (b !== 1'b1) blow++;
            end else begin
                if (!use7) begin
                    gap4_q.push_back(idle);
                    blow4_q.push_back(blow);
                    fs4_q.push_back(int'(fs4));
                end
                idle = 0; blow = 0; bad = 0; bsy = 0; aborted = 1'b0; first = 1'b0;
                for (int n = 0; n < 100 * div; n++) begin
                    if (n != 0) begin
                        @(negedge clk);
                        t = use7 ? tx7 : tx4;
                        b = use7 ? busy7 : busy4;
                    end
                    if (reset !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (b === 1'b1) bsy++;
                    if (n % div == 0) begin
                        first = t;
                        bit_i = (n / div) % 10;
                        if (bit_i == 0 && t !== 1'b0) bad++;
                        else if (bit_i == 9 && t !== 1'b1) bad++;
                        else if (bit_i >= 1 && bit_i <= 8) by[n / (10 * div)][bit_i - 1] = t;
                    end else if (t !== first) begin
                        bad++;
                    end
                end
                if (!aborted) begin
                    check($sformatf("mon%0d_bit_timing", div), 64'(bad), 64'd0);
                    check($sformatf("mon%0d_busy_in_frame", div), 64'(bsy), 64'(100 * div));
                    for (int i = 0; i < 10; i++) begin
                        e = 8'hxx;
                        if (use7 && exp7_q.size() > 0) e = exp7_q.pop_front();
                        else if (!use7 && exp4_q.size() > 0) e = exp4_q.pop_front();
                        check($sformatf("mon%0d_byte%0d", div, i), 64'(by[i]), 64'(e));
                    end
                    if (use7) frames_seen7++;
                    else begin
                        frames_seen4++;
                        last_csum4 = by[9];
                    end
                end
            end
        end
    endtask

    initial mon(1'b0);
    initial mon(1'b1);

    task automatic wait_frames(input bit use7, input int target, input int limit, input string tag);
        int n;
        n = 0;
        while (((use7 ? frames_seen7 : frames_seen4) < target) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'((use7 ? frames_seen7 : frames_seen4) >= target), 64'd1);
    endtask

    initial begin
        int seen, viol, g, bl, f;
        reset       = 1'b1;
        if4.s_valid = 1'b0;
        if4.s_data  = 64'h0;
        if7.s_valid = 1'b0;
        if7.s_data  = 64'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_tx4", 64'(tx4), 64'd1);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_ready4", 64'(if4.s_ready), 64'd1);
        check("rst_frames4", 64'(fs4), 64'd0);
        check("rst_tx7", 64'(tx7), 64'd1);
        check("rst_frames7", 64'(fs7), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, exact latency and busy window
        if4.s_data  = 64'h3FE870B3B839FEE6;
        if4.s_valid = 1'b1;
        sb_push(1'b0, 64'h3FE870B3B839FEE6);
        @(negedge clk);
        if4.s_valid = 1'b0;
        check("t1_load_tx", 64'(tx4), 64'd1);
        check("t1_load_busy", 64'(busy4), 64'd1);
        @(negedge clk);
        check("t1_start_at_push_plus2", 64'(tx4), 64'd0);
        repeat (399) @(negedge clk);
        check("t1_last_stop_busy", 64'(busy4), 64'd1);
        check("t1_last_stop_tx", 64'(tx4), 64'd1);
        @(negedge clk);
        check("t1_busy_fall", 64'(busy4), 64'd0);
        check("t1_frames_sent", 64'(fs4), 64'd1);
        check("t1_idle_tx", 64'(tx4), 64'd1);
        check("t1_csum_8d", 64'(last_csum4), 64'h8D);

        // Bit timing at CLK_DIV=7 with an all-zero sample
        if7.s_data  = 64'h0;
        if7.s_valid = 1'b1;
        sb_push(1'b1, 64'h0);
        @(negedge clk);
        if7.s_valid = 1'b0;
        wait_frames(1'b1, 1, 1000, "t2_frame_done");
        @(negedge clk);
        check("t2_frames_sent", 64'(fs7), 64'd1);
        check("t2_busy_fall", 64'(busy7), 64'd0);

        // Backpressure: 8 consecutive offers, 5 taken
        gap4_q.delete();
        blow4_q.delete();
        fs4_q.delete();
        for (int i = 1; i <= 8; i++) begin
            if4.s_data  = 64'(i);
            if4.s_valid = 1'b1;
            check($sformatf("t3_ready_cyc%0d", i), 64'(if4.s_ready), 64'(i <= 5));
            if (i <= 5) sb_push(1'b0, 64'(i));
            @(negedge clk);
        end
        if4.s_valid = 1'b0;
        repeat (394) @(negedge clk);

        // LOAD of sample 2 while full: offer refused, then taken next cycle
        check("t6_ready_on_load", 64'(if4.s_ready), 64'd0);
        check("t4_load_tx_high", 64'(tx4), 64'd1);
        check("t4_load_busy", 64'(busy4), 64'd1);
        check("t4_frames_after_1", 64'(fs4), 64'd2);
        if4.s_data  = 64'd9;
        if4.s_valid = 1'b1;
        @(negedge clk);
        check("t3_ready_return", 64'(if4.s_ready), 64'd1);
        check("t4_next_start", 64'(tx4), 64'd0);
        sb_push(1'b0, 64'd9);
        @(negedge clk);
        if4.s_valid = 1'b0;
        wait_frames(1'b0, 7, 6 * 410, "t3_all_frames");
        repeat (3) @(negedge clk);
        check("t3_frames_total", 64'(fs4), 64'd7);
        check("t3_idle_busy", 64'(busy4), 64'd0);
        check("t3_scoreboard_empty", 64'(exp4_q.size()), 64'd0);

        // Back-to-back spacing and frames_sent stepping
        check("t4_frame_records", 64'(gap4_q.size()), 64'd6);
        for (int k = 0; k < 6 && gap4_q.size() > 0; k++) begin
            g  = gap4_q.pop_front();
            bl = blow4_q.pop_front();
            f  = fs4_q.pop_front();
            check($sformatf("t4_fs_at_start%0d", k), 64'(f), 64'(1 + k));
            if (k > 0) begin
                check($sformatf("t4_gap%0d", k), 64'(g), 64'd1);
                check($sformatf("t4_busy_gap%0d", k), 64'(bl), 64'd0);
            end
        end

        // Reset during DATA byte 3 with a second sample queued
        if4.s_data  = 64'h0123456789ABCDEF;
        if4.s_valid = 1'b1;
        sb_push(1'b0, 64'h0123456789ABCDEF);
        @(negedge clk);
        if4.s_data = 64'hFEDCBA9876543210;
        sb_push(1'b0, 64'hFEDCBA9876543210);
        @(negedge clk);
        if4.s_valid = 1'b0;
        check("t5_start", 64'(tx4), 64'd0);
        repeat (168) @(negedge clk);
        check("t5_mid_frame_busy", 64'(busy4), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_tx", 64'(tx4), 64'd1);
        check("t5_busy", 64'(busy4), 64'd0);
        check("t5_ready", 64'(if4.s_ready), 64'd1);
        check("t5_frames", 64'(fs4), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp4_q.delete();
        gap4_q.delete();
        blow4_q.delete();
        fs4_q.delete();
        seen = frames_seen4;
        viol = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx4 !== 1'b1 || busy4 !== 1'b0) viol++;
        end
        check("t5_no_resume", 64'(viol), 64'd0);
        check("t5_no_frames", 64'(frames_seen4), 64'(seen));

        // Recovery after reset
        if4.s_data  = 64'hC00921FB54442D18;
        if4.s_valid = 1'b1;
        sb_push(1'b0, 64'hC00921FB54442D18);
        @(negedge clk);
        if4.s_valid = 1'b0;
        wait_frames(1'b0, seen + 1, 500, "t7_frame_done");
        repeat (2) @(negedge clk);
        check("t7_frames", 64'(fs4), 64'd1);
        check("t7_busy", 64'(busy4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
